// File: rtl/add_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_acc_pkg
// Description : Shared definitions for the add_accumulator block: frame state
//               encoding, default widths and a saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package add_acc_pkg;

    localparam int C_DEF_N     = 6;
    localparam int C_DEF_CNT_W = 4;

    // ACCUM: collecting operands of the current frame.
    // HOLD : frame result presented, waiting for the consumer.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Adds inc to val but never past max. Kept 32 bits wide so any counter
    // width up to 32 can share it; callers zero-extend and truncate.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic        inc,
                                            input logic [31:0] max);
        if (inc && (val != max))
            sat_inc = val + 32'd1;
        else
            sat_inc = val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module      : adder
// Description : N-bit combinational adder with carry-out.
//   a, b : N-bit addends
//   s    : N-bit sum (a + b mod 2^N)
//   c    : carry-out of the addition
// Revision    : 1.0 - initial release
// ============================================================================
module adder #(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         c
);

    assign {c, s} = a + b;

endmodule
`default_nettype wire

// File: rtl/add_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : add_accumulator
// Description : Streaming multi-operand accumulator. Operands are summed
//               through one adder instance; carry-outs are counted so the
//               frame result is carry_cnt * 2^N + sum. A beat with in_last
//               closes the frame and the result is offered on a valid/ready
//               output until the consumer takes it.
//   clk, rst_n         : clock (rising edge), async active-low reset
//   in_valid/in_ready  : operand handshake; in_data operand, in_last frame end
//   out_valid/out_ready: result handshake
//   out_sum            : low N bits of the frame sum
//   out_carry_cnt      : adder carry-outs in the frame (saturating)
//   out_count          : operands in the frame (saturating)
//   out_ovf            : a counter saturated during the frame
// Revision    : 1.0 - initial release
// ============================================================================
module add_accumulator
    import add_acc_pkg::*;
#(
    parameter int N     = C_DEF_N,
    parameter int CNT_W = C_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic [CNT_W-1:0] out_carry_cnt,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    logic             r_ready_en;   // holds in_ready low until the first clock after reset
    logic [N-1:0]     r_acc;
    logic [CNT_W-1:0] r_carry_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic [N-1:0]     w_s;
    logic             w_c;
    logic             w_accept;
    logic [CNT_W-1:0] w_carry_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_ovf_nxt;

    adder #(.N(N)) u_adder (
        .a (r_acc),
        .b (in_data),
        .s (w_s),
        .c (w_c)
    );

    assign in_ready  = (r_state == ACCUM) && r_ready_en;
    assign out_valid = (r_state == HOLD);
    assign w_accept  = in_valid && in_ready;

    // Post-update counter values for an accepted beat.
    always_comb begin
        w_carry_nxt = CNT_W'(sat_inc(32'(r_carry_cnt), w_c,  32'(C_CNT_MAX)));
        w_count_nxt = CNT_W'(sat_inc(32'(r_count),     1'b1, 32'(C_CNT_MAX)));
        w_ovf_nxt   = r_ovf
                    || (w_c && (r_carry_cnt == C_CNT_MAX))
                    || (r_count == C_CNT_MAX);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_accept && in_last) w_state_nxt = HOLD;
            HOLD:    if (out_ready)           w_state_nxt = ACCUM;
            default:                          w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ACCUM;
            r_ready_en    <= 1'b0;
            r_acc         <= '0;
            r_carry_cnt   <= '0;
            r_count       <= '0;
            r_ovf         <= 1'b0;
            out_sum       <= '0;
            out_carry_cnt <= '0;
            out_count     <= '0;
            out_ovf       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_acc       <= w_s;
                r_carry_cnt <= w_carry_nxt;
                r_count     <= w_count_nxt;
                r_ovf       <= w_ovf_nxt;
                if (in_last) begin
                    out_sum       <= w_s;
                    out_carry_cnt <= w_carry_nxt;
                    out_count     <= w_count_nxt;
                    out_ovf       <= w_ovf_nxt;
                end
            end else if ((r_state == HOLD) && out_ready) begin
                // Result consumed: start the next frame from zero. The out_*
                // registers keep the last result for observation.
                r_acc       <= '0;
                r_carry_cnt <= '0;
                r_count     <= '0;
                r_ovf       <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_accumulator
// Description : Directed self-checking bench for add_accumulator (N=6,
//               CNT_W=4) with hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_add_accumulator;

    localparam int N     = 6;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic [CNT_W-1:0] out_carry_cnt;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    add_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_carry_cnt (out_carry_cnt),
        .out_count     (out_count),
        .out_ovf       (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input int sum, input int carry,
                              input int cnt, input int ovf);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"},   32'(out_sum), 32'(sum));
        chk({tag, "_carry"}, 32'(out_carry_cnt), 32'(carry));
        chk({tag, "_count"}, 32'(out_count), 32'(cnt));
        chk({tag, "_ovf"},   32'(out_ovf), 32'(ovf));
        chk({tag, "_rdy"},   32'(in_ready), 32'd0);
    endtask

    // Present one beat, let one rising edge pass, sample 1ns after it.
    task automatic beat(input logic [N-1:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Take the held result; the block must return to ACCUM on the next edge.
    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy"},  32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_rdy",   32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",   32'(out_sum), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_rdy", 32'(in_ready), 32'd1);

        // 5 + 7 = 12
        beat(6'd5, 1'b0);
        chk("f1_mid_valid", 32'(out_valid), 32'd0);
        beat(6'd7, 1'b1);
        chk_result("f1", 12, 0, 2, 0);
        consume("f1");

        // 63 + 1 = 64 -> 0 with carry, + 2 = 2
        beat(6'd63, 1'b0);
        beat(6'd1,  1'b0);
        beat(6'd2,  1'b1);
        chk_result("f2", 2, 1, 3, 0);
        consume("f2");

        // 17 x 63 = 1071 -> 47 mod 64; 16 carries and 17 beats both saturate
        for (int i = 0; i < 17; i++)
            beat(6'd63, (i == 16) ? 1'b1 : 1'b0);
        chk_result("f3", 47, 15, 15, 1);
        consume("f3");

        // Backpressure: result 15 held while in_valid with unknown data
        beat(6'd15, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 'x;
            @(posedge clk);
            #1;
            chk_result("bp", 15, 0, 1, 0);
        end
        in_valid = 1'b0;
        in_data  = '0;
        consume("bp");
        beat(6'd2, 1'b1);
        chk_result("bp_next", 2, 0, 1, 0);
        consume("bp_next");

        // Single-beat frame
        beat(6'd6, 1'b1);
        chk_result("single", 6, 0, 1, 0);
        consume("single");

        // Asynchronous reset mid-frame (40 + 40 would carry)
        beat(6'd40, 1'b0);
        beat(6'd40, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rdy",   32'(in_ready), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_sum",   32'(out_sum), 32'd0);
        chk("arst_count", 32'(out_count), 32'd0);
        chk("arst_carry", 32'(out_carry_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(6'd3, 1'b1);
        chk_result("post_rst", 3, 0, 1, 0);
        consume("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
